multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multicycle main-control FSM: the producer of alu_control and all datapath enables consumed by alu32.
//  Decodes opcode/funct from the instruction register and sequences FETCH..WRITEBACK.
//  Waits on a memory ready handshake and takes branch decisions from the ALU zero flag (zout).
//  Flags illegal instructions and memory timeouts.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles waiting for mem_ready before fault; 0 disables timeout
//  CNT_W        8    width of wait counter (must hold MEM_TIMEOUT)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  opcode       in   6   IR[31:26]
//  funct        in   6   IR[5:0]
//  zout         in   1   ALU zero flag
//  mem_ready    in   1   memory completes current read/write this cycle
//  alu_control  out  3   000 AND,001 OR,010 ADD,011 XOR,100 NAND,101 SLL,110 SUB,111 SLT
//  alu_src_a    out  1   0=PC, 1=reg A
//  alu_src_b    out  2   00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  pc_source    out  2   00=ALU result, 01=ALUOut, 10=jump target
//  pc_en        out  1   PC load enable
//  iord         out  1   0=PC address, 1=ALUOut address
//  mem_read     out  1   memory read request
//  mem_write    out  1   memory write request
//  ir_write     out  1   IR load enable
//  reg_dst      out  1   0=rt, 1=rd
//  mem_to_reg   out  1   0=ALUOut, 1=MDR
//  reg_write    out  1   register-file write enable
//  fault        out  1   1-cycle pulse: illegal instruction or memory timeout
//  state        out  4   current state (debug)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEM_ADDR=2 MEM_RD=3 MEM_WB=4 MEM_WR=5 EXEC=6 ALU_WB=7 BRANCH=8 JUMP=9 ADDI_EX=10 ADDI_WB=11 TRAP=15.
//  Reset (rst_n low, asynchronous): state=FETCH, wait counter=0. All outputs are 0 while rst_n is low, including mem_read.
//  Reset mid-operation aborts immediately; no pending write is completed.
//  Outputs are decoded from state (Moore), except pc_en, ir_write, mem_write hold, and branch, as noted. Unlisted outputs are 0.
//  FETCH: mem_read=1, iord=0, src_a=0, src_b=01, ADD, pc_source=00.
//    ir_write=pc_en=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
//  DECODE: src_a=0, src_b=11, ADD (branch target into ALUOut). Next state by opcode:
//    00h -> EXEC if funct legal, else TRAP. 23h/2Bh -> MEM_ADDR. 04h -> BRANCH.
//    08h -> ADDI_EX. 02h -> JUMP. Any other opcode -> TRAP.
//  Legal funct: 24h AND, 25h OR, 20h ADD, 26h XOR, 27h NAND, 00h SLL, 22h SUB, 2Ah SLT.
//  MEM_ADDR: src_a=1, src_b=10, ADD. Next: MEM_RD for lw, MEM_WR for sw.
//  MEM_RD: mem_read=1, iord=1. Waits for mem_ready, then MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
//  MEM_WR: mem_write=1, iord=1, held until mem_ready=1, then FETCH.
//  EXEC: src_a=1, src_b=00, alu_control from funct, then ALU_WB. ALU_WB: reg_write=1, reg_dst=1, then FETCH.
//  BRANCH: src_a=1, src_b=00, SUB, pc_source=01, pc_en=zout (same cycle), then FETCH.
//  JUMP: pc_source=10, pc_en=1, then FETCH.
//  ADDI_EX: src_a=1, src_b=10, ADD. ADDI_WB: reg_write=1, reg_dst=0, then FETCH.
//  TRAP: fault=1 for exactly one cycle, no enables asserted, then FETCH (PC already advanced).
//  Wait counter: clears on every state change. Increments each cycle spent in FETCH/MEM_RD/MEM_WR with mem_ready=0.
//    If MEM_TIMEOUT!=0 and the count reaches MEM_TIMEOUT with mem_ready still 0, next state is TRAP.
//  mem_ready arriving on the limit cycle wins: the access completes and no fault is raised.
//  Counter saturates; it never wraps.
//  mem_ready is ignored outside FETCH/MEM_RD/MEM_WR. zout is ignored outside BRANCH.
// TESTING
//  Reset: assert rst_n=0 mid-MEM_WR -> all outputs 0 at once; release -> state=0, mem_read=1.
//  R-type: opcode=00 funct=22h, mem_ready=1 in FETCH -> states 0,1,6,7,0; alu_control=110 in EXEC; reg_write=1 only in ALU_WB.
//  lw with 3-cycle memory: mem_ready low 2 cycles in MEM_RD -> stays in state 3 three cycles, then MEM_WB with mem_to_reg=1.
//  beq: zout=1 in BRANCH -> pc_en=1 and pc_source=01; zout=0 -> pc_en=0. Both return to FETCH.
//  Illegal: opcode=3Fh, or opcode=00 with funct=01h -> TRAP, fault pulses exactly 1 cycle, then FETCH.
//  Timeout: MEM_TIMEOUT=4 and mem_ready held 0 in FETCH -> TRAP after 4 waiting cycles, fault=1.
//    Repeat with mem_ready=1 on the 4th cycle -> DECODE, no fault.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle main-control FSM: sequences FETCH..WRITEBACK, drives every datapath enable
// and alu_control, waits on the memory handshake and flags illegal opcodes and timeouts.
module multicycle_control #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zout,
   input  logic       mem_ready,
   output logic [2:0] alu_control,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       fault,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      EXEC     = 4'd6,
      ALU_WB   = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9,
      ADDI_EX  = 4'd10,
      ADDI_WB  = 4'd11,
      TRAP     = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;

   // Timeout fires on the cycle the count would reach MEM_TIMEOUT (unused when MEM_TIMEOUT is 0).
   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MEM_TIMEOUT - 1);

   state_t           cur_state, next_state;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
   logic [2:0]       funct_alu;
   logic             funct_legal;
   logic             waiting;
   logic             timed_out;

   always_comb begin
      funct_legal = 1'b1;
      funct_alu   = 3'b000;
      case (funct)
         6'h24:   funct_alu = 3'b000;
         6'h25:   funct_alu = 3'b001;
         6'h20:   funct_alu = 3'b010;
         6'h26:   funct_alu = 3'b011;
         6'h27:   funct_alu = 3'b100;
         6'h00:   funct_alu = 3'b101;
         6'h22:   funct_alu = 3'b110;
         6'h2A:   funct_alu = 3'b111;
         default: funct_legal = 1'b0;
      endcase
   end

   assign waiting   = ((cur_state == FETCH) || (cur_state == MEM_RD) || (cur_state == MEM_WR))
                      && !mem_ready;
   assign timed_out = waiting && (MEM_TIMEOUT != 0) && (wait_cnt >= LIMIT_M1);

   always_comb begin
      next_state = cur_state;
      case (cur_state)
         FETCH:    if (mem_ready) next_state = DECODE;
                   else if (timed_out) next_state = TRAP;
         DECODE: begin
            case (opcode)
               OP_RTYPE:     next_state = funct_legal ? EXEC : TRAP;
               OP_LW, OP_SW: next_state = MEM_ADDR;
               OP_BEQ:       next_state = BRANCH;
               OP_ADDI:      next_state = ADDI_EX;
               OP_J:         next_state = JUMP;
               default:      next_state = TRAP;
            endcase
         end
         MEM_ADDR: next_state = (opcode == OP_SW) ? MEM_WR : MEM_RD;
         MEM_RD:   if (mem_ready) next_state = MEM_WB;
                   else if (timed_out) next_state = TRAP;
         MEM_WR:   if (mem_ready) next_state = FETCH;
                   else if (timed_out) next_state = TRAP;
         EXEC:     next_state = ALU_WB;
         ADDI_EX:  next_state = ADDI_WB;
         default:  next_state = FETCH;
      endcase
   end

   // Counter restarts on every state change and saturates instead of wrapping.
   always_comb begin
      wait_cnt_next = wait_cnt;
      if (next_state != cur_state)
         wait_cnt_next = '0;
      else if (waiting && (wait_cnt != '1))
         wait_cnt_next = wait_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= FETCH;
         wait_cnt  <= '0;
      end else begin
         cur_state <= next_state;
         wait_cnt  <= wait_cnt_next;
      end
   end

   // Outputs are forced low combinationally while reset is held, even though FETCH is the reset state.
   always_comb begin
      alu_control = 3'b000;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      pc_source   = 2'b00;
      pc_en       = 1'b0;
      iord        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      fault       = 1'b0;
      if (rst_n) begin
         case (cur_state)
            FETCH: begin
               mem_read    = 1'b1;
               alu_src_b   = 2'b01;
               alu_control = ALU_ADD;
               ir_write    = mem_ready;
               pc_en       = mem_ready;
            end
            DECODE: begin
               alu_src_b   = 2'b11;
               alu_control = ALU_ADD;
            end
            MEM_ADDR, ADDI_EX: begin
               alu_src_a   = 1'b1;
               alu_src_b   = 2'b10;
               alu_control = ALU_ADD;
            end
            MEM_RD: begin
               mem_read = 1'b1;
               iord     = 1'b1;
            end
            MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            MEM_WR: begin
               mem_write = 1'b1;
               iord      = 1'b1;
            end
            EXEC: begin
               alu_src_a   = 1'b1;
               alu_control = funct_alu;
            end
            ALU_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            BRANCH: begin
               alu_src_a   = 1'b1;
               alu_control = ALU_SUB;
               pc_source   = 2'b01;
               pc_en       = zout;
            end
            JUMP: begin
               pc_source = 2'b10;
               pc_en     = 1'b1;
            end
            ADDI_WB:  reg_write = 1'b1;
            TRAP:     fault     = 1'b1;
            default:  ;
         endcase
      end
   end

   assign state = rst_n ? cur_state : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: builds an expected per-cycle trace for each
// instruction from its class and memory latencies, then drives and compares cycle by cycle.
module tb_multicycle_control;

   localparam int TMO = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode, funct;
   logic       zout, mem_ready;
   logic [2:0] alu_control;
   logic       alu_src_a;
   logic [1:0] alu_src_b, pc_source;
   logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, fault;
   logic [3:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic        rdy;
      logic        z;
      logic [20:0] exp;
   } cyc_t;

   cyc_t plan[$];

   multicycle_control #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zout(zout),
      .mem_ready(mem_ready), .alu_control(alu_control), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .pc_source(pc_source), .pc_en(pc_en), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .fault(fault), .state(state)
   );

   always #5 clk = ~clk;

   wire [20:0] observed = {alu_control, alu_src_a, alu_src_b, pc_source, pc_en, iord, mem_read,
                           mem_write, ir_write, reg_dst, mem_to_reg, reg_write, fault, state};

   function automatic logic [20:0] vec(input logic [2:0] alu, input logic sa, input logic [1:0] sb,
                                       input logic [1:0] ps, input logic pe, input logic io,
                                       input logic mr, input logic mw, input logic irw,
                                       input logic rd, input logic m2r, input logic rw,
                                       input logic f, input logic [3:0] st);
      return {alu, sa, sb, ps, pe, io, mr, mw, irw, rd, m2r, rw, f, st};
   endfunction

   // {legal, alu code} straight from the instruction set's funct table
   function automatic logic [3:0] funct_op(input logic [5:0] fn);
      case (fn)
         6'h24:   return 4'b1_000;
         6'h25:   return 4'b1_001;
         6'h20:   return 4'b1_010;
         6'h26:   return 4'b1_011;
         6'h27:   return 4'b1_100;
         6'h00:   return 4'b1_101;
         6'h22:   return 4'b1_110;
         6'h2A:   return 4'b1_111;
         default: return 4'b0_000;
      endcase
   endfunction

   function automatic logic [20:0] v_fetch_busy(); return vec(3'b010,0,2'b01,2'b00,0,0,1,0,0,0,0,0,0,4'd0); endfunction
   function automatic logic [20:0] v_fetch_done(); return vec(3'b010,0,2'b01,2'b00,1,0,1,0,1,0,0,0,0,4'd0); endfunction
   function automatic logic [20:0] v_mem_wr();     return vec(3'b000,0,2'b00,2'b00,0,1,0,1,0,0,0,0,0,4'd5); endfunction
   function automatic logic [20:0] v_trap();       return vec(3'b000,0,2'b00,2'b00,0,0,0,0,0,0,0,0,1,4'd15); endfunction

   function automatic void push(input logic rdy, input logic z, input logic [20:0] e);
      cyc_t c;
      c.rdy = rdy; c.z = z; c.exp = e;
      plan.push_back(c);
   endfunction

   // A memory wait of lat not-ready cycles; a wait reaching TMO cycles ends in TRAP instead.
   task automatic add_wait(input logic [20:0] busy, input logic [20:0] done, input int lat,
                           output logic timed_out);
      for (int i = 0; i < lat && i < TMO; i++) push(1'b0, 1'($urandom), busy);
      timed_out = (lat >= TMO);
      if (timed_out) push(1'($urandom), 1'($urandom), v_trap());
      else           push(1'b1, 1'($urandom), done);
   endtask

   task automatic build_instr(input logic [5:0] op, input logic [5:0] fn, input int fl,
                              input int ml, input logic z);
      logic       to;
      logic [3:0] fo;
      add_wait(v_fetch_busy(), v_fetch_done(), fl, to);
      if (to) return;
      push(1'($urandom), 1'($urandom), vec(3'b010,0,2'b11,2'b00,0,0,0,0,0,0,0,0,0,4'd1));
      case (op)
         6'h00: begin
            fo = funct_op(fn);
            if (fo[3]) begin
               push(1'($urandom), 1'($urandom), vec(fo[2:0],1,2'b00,2'b00,0,0,0,0,0,0,0,0,0,4'd6));
               push(1'($urandom), 1'($urandom), vec(3'b000,0,2'b00,2'b00,0,0,0,0,0,1,0,1,0,4'd7));
            end else push(1'($urandom), 1'($urandom), v_trap());
         end
         6'h23: begin
            push(1'($urandom), 1'($urandom), vec(3'b010,1,2'b10,2'b00,0,0,0,0,0,0,0,0,0,4'd2));
            add_wait(vec(3'b000,0,2'b00,2'b00,0,1,1,0,0,0,0,0,0,4'd3),
                     vec(3'b000,0,2'b00,2'b00,0,1,1,0,0,0,0,0,0,4'd3), ml, to);
            if (!to) push(1'($urandom), 1'($urandom), vec(3'b000,0,2'b00,2'b00,0,0,0,0,0,0,1,1,0,4'd4));
         end
         6'h2B: begin
            push(1'($urandom), 1'($urandom), vec(3'b010,1,2'b10,2'b00,0,0,0,0,0,0,0,0,0,4'd2));
            add_wait(v_mem_wr(), v_mem_wr(), ml, to);
         end
         6'h04: push(1'($urandom), z, vec(3'b110,1,2'b00,2'b01,z,0,0,0,0,0,0,0,0,4'd8));
         6'h08: begin
            push(1'($urandom), 1'($urandom), vec(3'b010,1,2'b10,2'b00,0,0,0,0,0,0,0,0,0,4'd10));
            push(1'($urandom), 1'($urandom), vec(3'b000,0,2'b00,2'b00,0,0,0,0,0,0,0,1,0,4'd11));
         end
         6'h02: push(1'($urandom), 1'($urandom), vec(3'b000,0,2'b00,2'b10,1,0,0,0,0,0,0,0,0,4'd9));
         default: push(1'($urandom), 1'($urandom), v_trap());
      endcase
   endtask

   // Plays the first n_run planned cycles (all when negative); starts and ends just after a rising edge.
   task automatic run_plan(input string name, input int n_run);
      int n = (n_run < 0) ? plan.size() : n_run;
      for (int i = 0; i < n; i++) begin
         mem_ready = plan[i].rdy;
         zout      = plan[i].z;
         @(negedge clk);
         n_checks++;
         if (observed !== plan[i].exp) begin
            n_fail++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, i, observed, plan[i].exp);
         end
         @(posedge clk);
         #1;
      end
      plan.delete();
   endtask

   task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input int fl, input int ml, input logic z);
      opcode = op;
      funct  = fn;
      build_instr(op, fn, fl, ml, z);
      run_plan(name, -1);
   endtask

   task automatic check_now(input string name, input logic [20:0] e);
      n_checks++;
      if (observed !== e) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", name, observed, e);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_ready = 1'b1; zout = 1'b1; opcode = 6'h00; funct = 6'h22;
      #3;
      check_now("reset_outputs_low", 21'd0);
      repeat (2) @(posedge clk);
      #1;
      check_now("reset_held", 21'd0);
      mem_ready = 1'b0;
      rst_n = 1'b1;
      #1;
      check_now("reset_release_fetch", v_fetch_busy());
   endtask

   task automatic test_rtype();
      run_instr("rtype_sub", 6'h00, 6'h22, 0, 0, 1'b0);
      run_instr("rtype_and_slow_fetch", 6'h00, 6'h24, 2, 0, 1'b0);
   endtask

   task automatic test_lw_latency();
      run_instr("lw_3cycle", 6'h23, 6'h00, 0, 2, 1'b0);
      run_instr("sw_ready_on_limit", 6'h2B, 6'h00, 1, 3, 1'b0);
   endtask

   task automatic test_branch();
      run_instr("beq_taken", 6'h04, 6'h00, 0, 0, 1'b1);
      run_instr("beq_not_taken", 6'h04, 6'h00, 0, 0, 1'b0);
   endtask

   task automatic test_illegal();
      run_instr("illegal_opcode", 6'h3F, 6'h00, 0, 0, 1'b0);
      run_instr("illegal_funct", 6'h00, 6'h01, 0, 0, 1'b0);
   endtask

   task automatic test_timeout();
      run_instr("fetch_timeout", 6'h00, 6'h20, 4, 0, 1'b0);
      run_instr("fetch_ready_on_limit", 6'h08, 6'h00, 3, 0, 1'b0);
      run_instr("lw_timeout", 6'h23, 6'h00, 3, 4, 1'b0);
      run_instr("sw_timeout", 6'h2B, 6'h00, 0, 6, 1'b0);
   endtask

   task automatic test_reset_mid_write();
      opcode = 6'h2B;
      funct  = 6'h00;
      build_instr(6'h2B, 6'h00, 0, 3, 1'b0);
      run_plan("sw_before_reset", 3);
      mem_ready = 1'b0;
      #1;
      check_now("in_mem_wr", v_mem_wr());
      rst_n = 1'b0;
      #1;
      check_now("reset_mid_write_immediate", 21'd0);
      @(posedge clk);
      #1;
      check_now("reset_mid_write_held", 21'd0);
      rst_n = 1'b1;
      #1;
      check_now("reset_mid_write_release", v_fetch_busy());
   endtask

   task automatic test_random();
      logic [5:0] ops[8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F, 6'h00};
      logic [5:0] fns[8] = '{6'h24, 6'h25, 6'h20, 6'h26, 6'h27, 6'h00, 6'h22, 6'h2A};
      logic [5:0] op, fn;
      for (int k = 0; k < 150; k++) begin
         op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
         fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
         run_instr("random", op, fn, $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_latency();
      test_branch();
      test_illegal();
      test_timeout();
      test_reset_mid_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
